and_xor_arbiter: RTL

Two-requester round-robin arbiter and sequencer for a shared WIDTH-bit bitwise AND/XOR function unit. It uses the same function-select encoding as the single-bit and_xor cell: 0 = AND, 1 = XOR. It accepts one operation at a time through valid/ready handshakes, executes it, and returns a registered, requester-tagged result on a valid/ready output channel. It sits between two client datapaths and the shared logic-op resource.

---
 rtl/and_xor_arbiter_if.sv | 40 ++++
 rtl/and_xor_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/and_xor_arbiter_if.sv
// Request/result channel bundle for and_xor_arbiter.
// The master side holds the two requesters and the result consumer. The slave side is the arbiter.
interface and_xor_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             i_req0_valid;
  logic [WIDTH-1:0] i_req0_op1;
  logic [WIDTH-1:0] i_req0_op2;
  logic             i_req0_funcSelect;
  logic             o_req0_ready;

  logic             i_req1_valid;
  logic [WIDTH-1:0] i_req1_op1;
  logic [WIDTH-1:0] i_req1_op2;
  logic             i_req1_funcSelect;
  logic             o_req1_ready;

  logic             o_res_valid;
  logic [WIDTH-1:0] o_res_data;
  logic             o_res_id;
  logic             i_res_ready;

  modport master (
    output i_req0_valid, i_req0_op1, i_req0_op2, i_req0_funcSelect,
    input  o_req0_ready,
    output i_req1_valid, i_req1_op1, i_req1_op2, i_req1_funcSelect,
    input  o_req1_ready,
    input  o_res_valid, o_res_data, o_res_id,
    output i_res_ready
  );

  modport slave (
    input  i_req0_valid, i_req0_op1, i_req0_op2, i_req0_funcSelect,
    output o_req0_ready,
    input  i_req1_valid, i_req1_op1, i_req1_op2, i_req1_funcSelect,
    output o_req1_ready,
    output o_res_valid, o_res_data, o_res_id,
    input  i_res_ready
  );
endinterface

// File: rtl/and_xor_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one shared WIDTH-bit AND/XOR unit.
// It accepts one operation, executes it, and holds a tagged result until the consumer takes it.
module and_xor_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  and_xor_arbiter_if.slave     bus,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_opCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_ptr;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic             r_func;
  logic             r_id;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_id;
  logic [CNT_W-1:0] r_op_count;

  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_deliver;

  // Function-select encoding matches the single-bit cell: 0 = AND, 1 = XOR.
  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sel
  );
    return sel ? (a ^ b) : (a & b);
  endfunction

  // The pointer breaks ties. A lone requester wins whatever the pointer says.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      w_req0_ready = bus.i_req0_valid & (~r_ptr | ~bus.i_req1_valid);
      w_req1_ready = bus.i_req1_valid & ( r_ptr | ~bus.i_req0_valid);
    end
  end

  assign w_deliver = r_res_valid & bus.i_res_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_func      <= 1'b0;
      r_id        <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req0_ready) begin
            r_op1   <= bus.i_req0_op1;
            r_op2   <= bus.i_req0_op2;
            r_func  <= bus.i_req0_funcSelect;
            r_id    <= 1'b0;
            r_state <= ST_EXEC;
          end else if (w_req1_ready) begin
            r_op1   <= bus.i_req1_op1;
            r_op2   <= bus.i_req1_op2;
            r_func  <= bus.i_req1_funcSelect;
            r_id    <= 1'b1;
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_res_data  <= f_logic_op(r_op1, r_op2, r_func);
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= ST_RESP;
        end

        ST_RESP: begin
          // The result stays frozen until the consumer takes it. Then the other requester gets priority.
          if (w_deliver) begin
            r_res_valid <= 1'b0;
            r_ptr       <= ~r_res_id;
            r_op_count  <= r_op_count + CNT_W'(1);
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_req0_ready = w_req0_ready;
  assign bus.o_req1_ready = w_req1_ready;
  assign bus.o_res_valid  = r_res_valid;
  assign bus.o_res_data   = r_res_data;
  assign bus.o_res_id     = r_res_id;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_opCount        = r_op_count;

endmodule
